// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the RAM burst read path.
package ram_pkg;

  localparam int unsigned DEF_D_WIDTH = 16;
  localparam int unsigned DEF_A_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Request, RAM read port and output stream bundle of the burst reader.
interface ram_burst_reader_if
  import ram_pkg::*;
#(
  parameter int unsigned D_WIDTH   = DEF_D_WIDTH,
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned LEN_WIDTH = A_WIDTH + 1
);

  logic                 req_valid;
  logic                 req_ready;
  logic [A_WIDTH-1:0]   req_addr;
  logic [LEN_WIDTH-1:0] req_len;
  logic [A_WIDTH-1:0]   address_read;
  logic [D_WIDTH-1:0]   data_read;
  logic                 out_valid;
  logic                 out_ready;
  logic [D_WIDTH-1:0]   out_data;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  // Reader side.
  modport master (
    input  req_valid, req_addr, req_len, data_read, out_ready,
    output req_ready, address_read, out_valid, out_data, out_last, busy, done
  );

  // Requester / RAM / sink side.
  modport slave (
    output req_valid, req_addr, req_len, data_read, out_ready,
    input  req_ready, address_read, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/ram_skid_fifo.sv
// Two-entry FIFO whose head entry is a flop, so the read side sees registered data.
module ram_skid_fifo #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] tail;

  // Caller guarantees no push into a full FIFO without a pop, and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
      valid <= 1'b0;
    end else if (push && !pop) begin
      if (count == 2'd0) head <= push_data;
      else               tail <= push_data;
      count <= count + 2'd1;
      valid <= 1'b1;
    end else if (!push && pop) begin
      head  <= tail;
      count <= count - 2'd1;
      valid <= (count == 2'd2);
    end else if (push && pop) begin
      if (count == 2'd1) begin
        head <= push_data;
      end else begin
        head <= tail;
        tail <= push_data;
      end
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read controller: issues one RAM read per cycle and streams words out with backpressure.
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int unsigned D_WIDTH   = DEF_D_WIDTH,
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned LEN_WIDTH = A_WIDTH + 1
) (
  input logic                clk,
  input logic                rst_n,
  ram_burst_reader_if.master bus
);

  localparam int unsigned BEAT_W = D_WIDTH + 1;

  rd_state_t            state, state_n;
  logic [A_WIDTH-1:0]   addr_q, addr_n;
  logic [LEN_WIDTH-1:0] remaining, remaining_n;
  logic                 req_ready_q, req_ready_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 in_flight, in_flight_last, in_flight_last_n;
  logic                 issue, accept, pop, issue_ok;
  logic [1:0]           fifo_count;
  logic [2:0]           occ;
  logic                 fifo_valid;
  logic [BEAT_W-1:0]    head;

  assign pop      = fifo_valid & bus.out_ready;
  // Occupancy one edge ahead: buffered words plus the read on its way back, minus this cycle's pop.
  assign occ      = 3'(fifo_count) + 3'(in_flight) - 3'(pop);
  assign issue_ok = (occ < 3'd2);

  always_comb begin
    state_n          = state;
    addr_n           = addr_q;
    remaining_n      = remaining;
    req_ready_n      = req_ready_q;
    busy_n           = busy_q;
    done_n           = 1'b0;
    issue            = 1'b0;
    accept           = 1'b0;
    in_flight_last_n = 1'b0;

    unique case (state)
      IDLE: accept = 1'b1;
      ISSUE: begin
        if (issue_ok) begin
          issue       = 1'b1;
          addr_n      = addr_q + A_WIDTH'(1);
          remaining_n = remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            in_flight_last_n = 1'b1;
            state_n          = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The done cycle doubles as the first cycle a new request can be taken.
        if (done_q) begin
          accept = 1'b1;
        end else if (occ == 3'd0) begin
          done_n      = 1'b1;
          req_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      state_n     = IDLE;
      busy_n      = 1'b0;
      req_ready_n = 1'b1;
      if (bus.req_valid) begin
        if (bus.req_len != '0) begin
          state_n     = ISSUE;
          addr_n      = bus.req_addr;
          remaining_n = bus.req_len;
          busy_n      = 1'b1;
          req_ready_n = 1'b0;
        end else begin
          done_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      remaining      <= '0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      state          <= state_n;
      addr_q         <= addr_n;
      remaining      <= remaining_n;
      req_ready_q    <= req_ready_n;
      busy_q         <= busy_n;
      done_q         <= done_n;
      in_flight      <= issue;
      in_flight_last <= in_flight_last_n;
    end
  end

  // RAM data returns the cycle after issue and is captured straight into the FIFO.
  ram_skid_fifo #(.W(BEAT_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_flight),
    .push_data({in_flight_last, bus.data_read}),
    .pop      (pop),
    .head     (head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign bus.req_ready    = req_ready_q;
  assign bus.address_read = addr_q;
  assign bus.out_valid    = fifo_valid;
  assign bus.out_data     = head[D_WIDTH-1:0];
  assign bus.out_last     = head[D_WIDTH];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader with a behavioural 1-cycle-latency RAM.
module tb_ram_burst_reader;
  import ram_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned LW = 6;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  ram_burst_reader_if #(.D_WIDTH(DW), .A_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ram_burst_reader #(.D_WIDTH(DW), .A_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [32];
  always @(posedge clk) bus.data_read <= mem[bus.address_read];

  beat_t sb[$];
  beat_t exp_beat;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: every accepted beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b, want none at %0t",
                 bus.out_data, bus.out_last, $time);
      end else begin
        exp_beat = sb.pop_front();
        check("beat", 32'({bus.out_last, bus.out_data}), 32'(exp_beat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input int addr, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.last = (i == len - 1);
      b.data = 16'h100 + 16'((addr + i) % 32);
      sb.push_back(b);
    end
  endtask

  task automatic drive_req(input int addr, input int len);
    bus.req_valid = 1'b1;
    bus.req_addr  = AW'(addr);
    bus.req_len   = LW'(len);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = bus.done;
      if (!seen) step();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},    32'(bus.req_ready),    32'd1);
    check({tag, "_address_read"}, 32'(bus.address_read), 32'd0);
    check({tag, "_out_valid"},    32'(bus.out_valid),    32'd0);
    check({tag, "_out_data"},     32'(bus.out_data),     32'd0);
    check({tag, "_out_last"},     32'(bus.out_last),     32'd0);
    check({tag, "_busy"},         32'(bus.busy),         32'd0);
    check({tag, "_done"},         32'(bus.done),         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrap_addr [4] = '{30, 31, 0, 1};

    for (int k = 0; k < 32; k++) mem[k] = 16'h100 + 16'(k);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_rst");
    step();

    // Basic burst: timing of valid, last, busy and done relative to the handshake.
    expect_burst(3, 4);
    drive_req(3, 4);
    @(negedge clk);
    check("t1_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t1_busy",      32'(bus.busy),                  32'(c <= 7));
      check("t1_done",      32'(bus.done),                  32'(c == 7));
      check("t1_out_valid", 32'(bus.out_valid),             32'(c >= 3 && c <= 6));
      check("t1_out_last",  32'(bus.out_valid & bus.out_last), 32'(c == 6));
      step();
    end

    // Address wrap at the top of the RAM.
    expect_burst(30, 4);
    drive_req(30, 4);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t2_address_read", 32'(bus.address_read), 32'(wrap_addr[c-1]));
      step();
    end
    wait_done("t2", 20);

    // Backpressure: sink stalls for cycles 5-9, issue must stall with the head held.
    expect_burst(0, 8);
    drive_req(0, 8);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus.out_ready = !(c >= 5 && c <= 9);
      @(negedge clk);
      if (c >= 6 && c <= 9) begin
        check("t3_hold_valid", 32'(bus.out_valid),    32'd1);
        check("t3_hold_data",  32'(bus.out_data),     32'h102);
        check("t3_stall_addr", 32'(bus.address_read), 32'd4);
      end
      step();
    end
    bus.out_ready = 1'b1;
    wait_done("t3", 30);

    // Zero-length request: accepted, immediate done, no data, never busy.
    drive_req(3, 0);
    @(negedge clk);
    check("t4_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t4_done",      32'(bus.done),      32'(c == 1));
      check("t4_busy",      32'(bus.busy),      32'd0);
      check("t4_out_valid", 32'(bus.out_valid), 32'd0);
      step();
    end

    // Reset after two words, then a fresh burst.
    expect_burst(10, 8);
    drive_req(10, 8);
    step();
    bus.req_valid = 1'b0;
    repeat (4) step();
    check("t5_words_before_reset", 32'(sb.size()), 32'd6);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset("t5_rst");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_busy",      32'(bus.busy),      32'd0);
    check("t5_post_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_post_done",      32'(bus.done),      32'd0);
    step();
    expect_burst(5, 2);
    drive_req(5, 2);
    step();
    bus.req_valid = 1'b0;
    wait_done("t5", 20);

    // A request held during a burst is taken in the done cycle.
    expect_burst(8, 3);
    drive_req(8, 3);
    @(negedge clk);
    check("t6_first_ready", 32'(bus.req_ready), 32'd1);
    step();
    expect_burst(20, 2);
    drive_req(20, 2);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("t6_req_ready", 32'(bus.req_ready), 32'(c == 6 || c >= 11));
      check("t6_done",      32'(bus.done),      32'(c == 6 || c == 11));
      check("t6_busy",      32'(bus.busy),      32'(c <= 11));
      step();
      if (c == 6) bus.req_valid = 1'b0;
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
